// File: rtl/gpio_in_debounce_if.sv
// ---------------------------------------------------------------------------
// gpio_in_debounce_if
// CPU register bus shared between the bus master and the gpio_in_debounce
// register window.
//   cs    : chip select from the bus decoder
//   wr    : write strobe (write happens when cs & wr at posedge clk)
//   addr  : byte address, only [3:2] decoded by the slave
//   wdata : write data
//   rdata : read data, combinational from addr[3:2], independent of cs
// ---------------------------------------------------------------------------
interface gpio_in_debounce_if;
  logic        cs;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output cs,
    output wr,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  cs,
    input  wr,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_in_debounce.sv
// ---------------------------------------------------------------------------
// gpio_in_debounce
// Per-pin input conditioner: 2-flop synchronizer, debounce counter and edge
// detector feeding clean levels to the GPIO input port, with a 4-word
// register window (DBCR, LVL, IER, ISR) and a registered level interrupt.
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   bus     : register bus (gpio_in_debounce_if.slave)
//   pin_in  : raw asynchronous pins
//   pin_out : debounced levels (same as LVL)
//   irq     : registered interrupt, |(ISR & IER)
//
// Optional build macro GPIO_IN_DEBOUNCE_BYPASS_EN adds DBCR[16] as a bypass
// bit: LVL then follows the synchronized pin directly and counters hold at 0.
// Without the macro DBCR[16] reads 0 and ignores writes.
// ---------------------------------------------------------------------------
module gpio_in_debounce #(
  parameter int              NPIN       = 8,
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] DB_DEFAULT = CNT_W'(50000)
) (
  input  logic                clk,
  input  logic                reset,
  gpio_in_debounce_if.slave   bus,
  input  logic [NPIN-1:0]     pin_in,
  output logic [NPIN-1:0]     pin_out,
  output logic                irq
);

  // Register fields are laid out for 8 pins; bits above NPIN never set.
  localparam logic [7:0]  PMASK = 8'((16'd1 << NPIN) - 16'd1);
  localparam logic [15:0] FMASK = {PMASK, PMASK};

  logic [NPIN-1:0]  s1_q, s2_q;
  logic [NPIN-1:0]  lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [NPIN];
  logic [CNT_W-1:0] cnt_d [NPIN];
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [15:0]      ier_q, ier_d;
  logic [15:0]      isr_q, isr_d;
  logic             irq_q, irq_d;
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
  logic             byp_q, byp_d;
`endif

  logic [CNT_W-1:0] thr_e;
  logic [CNT_W-1:0] thr_em1;
  logic [7:0]       rise8, fall8;
  logic [15:0]      w1c;
  logic             wr_en;
  logic [1:0]       sel;
  logic             unused_bits;

  assign wr_en       = bus.cs & bus.wr;
  assign sel         = bus.addr[3:2];
  assign unused_bits = ^{bus.addr, bus.wdata};

  always_comb begin
    // Threshold 0 behaves as 1 so a zero write cannot stall the counter.
    thr_e   = (thr_q == '0) ? CNT_W'(1) : thr_q;
    thr_em1 = thr_e - CNT_W'(1);

    // Debounce: flip LVL on the thr_e-th consecutive mismatching cycle.
    // The >= compare also handles the threshold being lowered mid-count.
    lvl_d = lvl_q;
    for (int i = 0; i < NPIN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] >= thr_em1) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
    if (byp_q) begin
      lvl_d = s2_q;
      for (int i = 0; i < NPIN; i++) begin
        cnt_d[i] = '0;
      end
    end
`endif

    // Edge detect on the LVL update itself so ISR sets on the same edge.
    rise8             = '0;
    fall8             = '0;
    rise8[NPIN-1:0]   = lvl_d & ~lvl_q;
    fall8[NPIN-1:0]   = ~lvl_d & lvl_q;

    thr_d = thr_q;
    ier_d = ier_q;
    w1c   = '0;
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
    byp_d = byp_q;
`endif
    if (wr_en) begin
      unique case (sel)
        2'd0: begin
          thr_d = bus.wdata[CNT_W-1:0];
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
          byp_d = bus.wdata[16];
`endif
        end
        2'd2:    ier_d = bus.wdata[15:0] & FMASK;
        2'd3:    w1c   = bus.wdata[15:0];
        default: ;
      endcase
    end

    // Set wins over a same-cycle W1C on the same bit.
    isr_d = (isr_q & ~w1c) | {fall8, rise8};
    irq_d = |(isr_q & ier_q);
  end

  always_comb begin
    bus.rdata = '0;
    unique case (sel)
      2'd0: begin
        bus.rdata[CNT_W-1:0] = thr_q;
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
        bus.rdata[16] = byp_q;
`endif
      end
      2'd1:    bus.rdata[NPIN-1:0] = lvl_q;
      2'd2:    bus.rdata[15:0]     = ier_q;
      default: bus.rdata[15:0]     = isr_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < NPIN; i++) begin
        cnt_q[i] <= '0;
      end
      thr_q <= DB_DEFAULT;
      ier_q <= '0;
      isr_q <= '0;
      irq_q <= 1'b0;
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
      byp_q <= 1'b0;
`endif
    end else begin
      // Synchronizer stage
      s1_q  <= pin_in;
      s2_q  <= s1_q;
      // Debounce / register stage
      lvl_q <= lvl_d;
      for (int i = 0; i < NPIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      thr_q <= thr_d;
      ier_q <= ier_d;
      isr_q <= isr_d;
      // Interrupt stage
      irq_q <= irq_d;
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
      byp_q <= byp_d;
`endif
    end
  end

  assign pin_out = lvl_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
module tb_gpio_in_debounce;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic       irq;

  gpio_in_debounce_if bus ();

  gpio_in_debounce #(
    .NPIN      (8),
    .CNT_W     (16),
    .DB_DEFAULT(16'd50000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        do_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  // Reference model: a pin's level flips when the last thr synchronized
  // samples (pin samples two edges old and older) all disagree with it.
  logic [7:0]  hist [$];
  int          thr_m;
  logic [7:0]  lvl_m;
  logic [15:0] isr_m, ier_m;
  logic        irq_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.cs    = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.cs    = 1'b0;
    bus.wr    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic model_edge(input logic [7:0] pin, input logic isr_wr, input logic [15:0] isr_wd,
                            input logic ier_wr, input logic [15:0] ier_wd);
    logic [7:0] nl, rise, fall, smp;
    bit         all_diff;
    int         sz;
    irq_m = |(isr_m & ier_m);
    nl    = lvl_m;
    sz    = hist.size();
    for (int i = 0; i < 8; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < thr_m; j++) begin
        smp = hist[sz-2-j];
        if (smp[i] == lvl_m[i]) all_diff = 1'b0;
      end
      if (all_diff) nl[i] = ~lvl_m[i];
    end
    rise = nl & ~lvl_m;
    fall = ~nl & lvl_m;
    if (isr_wr) isr_m = isr_m & ~isr_wd;
    isr_m = isr_m | {fall, rise};
    if (ier_wr) ier_m = ier_wd;
    lvl_m = nl;
    hist.push_back(pin);
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  cur_pin;
    logic        isr_wr, ier_wr;
    logic [15:0] wd;
    int          op;

    tbl[0] = '{1'b0, 32'h0,  32'h0,         32'h0000_C350};
    tbl[1] = '{1'b0, 32'h4,  32'h0,         32'h0};
    tbl[2] = '{1'b0, 32'h8,  32'h0,         32'h0};
    tbl[3] = '{1'b0, 32'hC,  32'h0,         32'h0};
`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
    tbl[4] = '{1'b1, 32'h0,  32'hFFFF_1234, 32'h0001_1234};
    tbl[5] = '{1'b0, 32'h10, 32'h0,         32'h0001_1234};
`else
    tbl[4] = '{1'b1, 32'h0,  32'hFFFF_1234, 32'h0000_1234};
    tbl[5] = '{1'b0, 32'h10, 32'h0,         32'h0000_1234};
`endif
    tbl[6] = '{1'b1, 32'h4,  32'h0000_00FF, 32'h0};
    tbl[7] = '{1'b1, 32'h8,  32'hFFFF_FFFF, 32'h0000_FFFF};
    tbl[8] = '{1'b1, 32'hC,  32'hFFFF_FFFF, 32'h0};
    tbl[9] = '{1'b1, 32'h8,  32'h0,         32'h0};

    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    pin_in = '0;

    // Reset for 3 cycles
    #1 reset = 1'b1;
    steps(3);
    reset = 1'b0;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_pin_out", {24'b0, pin_out}, 32'h0);

    // Register table
    for (int v = 0; v < 10; v++) begin
      if (tbl[v].do_wr) bus_write(tbl[v].addr, tbl[v].wdata);
      rd(tbl[v].addr, d);
      chk($sformatf("regvec[%0d]", v), d, tbl[v].exp);
    end

    // Basic debounce with thr 4
    bus_write(32'h0, 32'd4);
    pin_in = 8'h01;
    steps(5);
    chk("deb_rise_early", {24'b0, pin_out}, 32'h00);
    step();
    chk("deb_rise_lvl", {24'b0, pin_out}, 32'h01);
    rd(32'hC, d); chk("deb_rise_isr", d, 32'h0000_0001);
    rd(32'h4, d); chk("deb_rise_lvlreg", d, 32'h0000_0001);
    pin_in = 8'h00;
    steps(6);
    chk("deb_fall_lvl", {24'b0, pin_out}, 32'h00);
    rd(32'hC, d); chk("deb_fall_isr", d, 32'h0000_0101);

    // Glitch of 3 cycles rejected, 4 cycles accepted
    bus_write(32'hC, 32'hFFFF);
    pin_in = 8'h08; steps(3);
    pin_in = 8'h00; steps(10);
    chk("glitch_lvl", {24'b0, pin_out}, 32'h00);
    rd(32'hC, d); chk("glitch_isr", d, 32'h0);
    pin_in = 8'h08; steps(4);
    pin_in = 8'h00; steps(3);
    chk("pulse4_lvl", {24'b0, pin_out}, 32'h08);
    rd(32'hC, d); chk("pulse4_isr", d, 32'h0000_0008);
    steps(6);
    chk("pulse4_fall_lvl", {24'b0, pin_out}, 32'h00);
    rd(32'hC, d); chk("pulse4_fall_isr", d, 32'h0000_0808);

    // Interrupt path
    bus_write(32'hC, 32'hFFFF);
    bus_write(32'h8, 32'h4);
    pin_in = 8'h04;
    steps(6);
    rd(32'hC, d); chk("irq_isr_set", d, 32'h0000_0004);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    step();
    chk("irq_asserted", {31'b0, irq}, 32'h1);
    bus_write(32'hC, 32'h4);
    rd(32'hC, d); chk("irq_w1c_isr", d, 32'h0);
    step();
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    pin_in = 8'h00;
    steps(6);
    rd(32'hC, d); chk("irq_fall_isr", d, 32'h0000_0400);
    steps(2);
    chk("irq_fall_masked", {31'b0, irq}, 32'h0);

    // Set vs W1C on the same edge
    bus_write(32'hC, 32'hFFFF);
    pin_in = 8'h01;
    steps(5);
    bus_write(32'hC, 32'h1);
    rd(32'hC, d); chk("collide_isr", d, 32'h0000_0001);
    chk("collide_lvl", {24'b0, pin_out}, 32'h01);

    // Threshold 0 acts as 1
    bus_write(32'h0, 32'h0);
    bus_write(32'hC, 32'hFFFF);
    pin_in = 8'h03;
    steps(2);
    chk("thr0_early", {24'b0, pin_out}, 32'h01);
    step();
    chk("thr0_lvl", {24'b0, pin_out}, 32'h03);
    rd(32'hC, d); chk("thr0_isr", d, 32'h0000_0002);

    // Lower threshold mid-count
    bus_write(32'h0, 32'd100);
    pin_in = 8'h13;
    steps(52);
    chk("lower_pre", {24'b0, pin_out}, 32'h03);
    bus_write(32'h0, 32'd2);
    chk("lower_wr_edge", {24'b0, pin_out}, 32'h03);
    step();
    chk("lower_flip", {24'b0, pin_out}, 32'h13);

`ifdef GPIO_IN_DEBOUNCE_BYPASS_EN
    bus_write(32'h0, 32'h0001_0064);
    pin_in = 8'h33;
    steps(2);
    chk("byp_early", {24'b0, pin_out}, 32'h13);
    step();
    chk("byp_rise", {24'b0, pin_out}, 32'h33);
    pin_in = 8'h13;
    steps(3);
    chk("byp_fall", {24'b0, pin_out}, 32'h13);
    bus_write(32'h0, 32'd3);
`endif

    // Reset mid-operation
    reset = 1'b1;
    step();
    chk("midrst_lvl", {24'b0, pin_out}, 32'h00);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    rd(32'h0, d); chk("midrst_dbcr", d, 32'h0000_C350);
    rd(32'h8, d); chk("midrst_ier", d, 32'h0);
    steps(2);
    reset = 1'b0;
    pin_in = 8'h00;
    steps(4);
    rd(32'hC, d); chk("midrst_isr", d, 32'h0);

    // Randomized run against the reference model
    bus_write(32'h0, 32'd3);
    steps(3);
    thr_m = 3; lvl_m = '0; isr_m = '0; ier_m = '0; irq_m = 1'b0;
    hist.delete();
    for (int k = 0; k < 8; k++) hist.push_back(8'h00);
    cur_pin = 8'h00;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) cur_pin[b] = ~cur_pin[b];
      pin_in = cur_pin;
      op = $urandom_range(0, 15);
      wd = 16'($urandom);
      isr_wr = (op < 2);
      ier_wr = (op == 2);
      if (isr_wr || ier_wr) begin
        bus.cs = 1'b1; bus.wr = 1'b1;
        bus.addr = isr_wr ? 32'hC : 32'h8;
        bus.wdata = {16'h0, wd};
      end
      step();
      bus.cs = 1'b0; bus.wr = 1'b0;
      model_edge(cur_pin, isr_wr, wd, ier_wr, wd);
      rd(32'hC, d);
      chk($sformatf("rnd_isr[%0d]", c), d, {16'h0, isr_m});
      chk($sformatf("rnd_lvl[%0d]", c), {24'b0, pin_out}, {24'b0, lvl_m});
      chk($sformatf("rnd_irq[%0d]", c), {31'b0, irq}, {31'b0, irq_m});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
